// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU controller: state enum, instruction
// field codes and the control-line encodings driven onto the datapath.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE, S_DECODE,
    S_MOVI, S_GET_A, S_GET_B, S_SHIFT, S_ALU, S_WR_C, S_LOADS,
    S_ADDR, S_LD_ADDR, S_MRD, S_WR_MEM, S_STR_B, S_STR_C, S_MWR,
    S_BR_TAKEN, S_BR_SKIP, S_LINK, S_BX_B, S_BX_C, S_BX_PC,
    S_HALT, S_ERR
  } state_t;

  localparam logic [2:0] OPC_BCOND = 3'b001;
  localparam logic [2:0] OPC_BLINK = 3'b010;
  localparam logic [2:0] OPC_LDR   = 3'b011;
  localparam logic [2:0] OPC_STR   = 3'b100;
  localparam logic [2:0] OPC_ALU   = 3'b101;
  localparam logic [2:0] OPC_MOV   = 3'b110;
  localparam logic [2:0] OPC_HALT  = 3'b111;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_BX   = 2'b00;
  localparam logic [1:0] OP_BLX  = 2'b10;
  localparam logic [1:0] OP_BL   = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC     = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_REL = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from the cond field and the N/Z/V flags, and flags unsupported conditions.
module br_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = (n ^ v) | z;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle controller: fetch/decode/execute sequencing with a timed memory
// handshake, conditional and link branches, resumable HALT and sticky ERR.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int BRANCH_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       Z,
  input  logic       V,
  input  logic       mem_rdy,
  input  logic       resume,
  output logic [3:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] nsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] pc_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       err,
  output state_t     dbg_state
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam bit BR_ON = (BRANCH_EN != 0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_last;
  logic             in_wait;
  logic             br_taken;
  logic             br_illegal;

  br_cond_eval u_br_cond_eval (
    .cond    (cond),
    .n       (N),
    .z       (Z),
    .v       (V),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  assign in_wait   = (state == S_IF1) || (state == S_MRD) || (state == S_MWR);
  assign wait_last = (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  // Any state change clears the counter, so each wait state starts from zero.
  always_ff @(posedge clk) begin
    if (reset)                    wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (in_wait)             wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:    state_next = S_IF1;
      S_IF1:    state_next = mem_rdy ? S_IF2 : (wait_last ? S_ERR : S_IF1);
      S_IF2:    state_next = S_UPDATE;
      S_UPDATE: state_next = S_DECODE;
      S_DECODE: begin
        case ({opcode, op})
          {OPC_MOV, OP_MOVI}:                    state_next = S_MOVI;
          {OPC_MOV, OP_MOV}, {OPC_ALU, OP_MVN}:  state_next = S_GET_B;
          {OPC_ALU, OP_ADD}, {OPC_ALU, OP_AND},
          {OPC_ALU, OP_CMP}:                     state_next = S_GET_A;
          {OPC_LDR, OP_NONE}, {OPC_STR, OP_NONE}: state_next = S_GET_A;
          {OPC_HALT, OP_NONE}:                   state_next = S_HALT;
          {OPC_BCOND, OP_NONE}: begin
            if (!BR_ON || br_illegal) state_next = S_ERR;
            else if (br_taken)        state_next = S_BR_TAKEN;
            else                      state_next = S_BR_SKIP;
          end
          {OPC_BLINK, OP_BL}, {OPC_BLINK, OP_BLX}: state_next = BR_ON ? S_LINK : S_ERR;
          {OPC_BLINK, OP_BX}:                      state_next = BR_ON ? S_BX_B : S_ERR;
          default:                                 state_next = S_ERR;
        endcase
      end
      S_MOVI:    state_next = S_IF1;
      S_GET_A:   state_next = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GET_B;
      S_GET_B: begin
        if (opcode == OPC_ALU && op == OP_CMP) state_next = S_LOADS;
        else if (opcode == OPC_MOV)            state_next = S_SHIFT;
        else                                   state_next = S_ALU;
      end
      S_SHIFT, S_ALU: state_next = S_WR_C;
      S_WR_C:     state_next = S_IF1;
      S_LOADS:    state_next = S_IF1;
      S_ADDR:     state_next = S_LD_ADDR;
      S_LD_ADDR:  state_next = (opcode == OPC_LDR) ? S_MRD : S_STR_B;
      S_MRD:      state_next = mem_rdy ? S_WR_MEM : (wait_last ? S_ERR : S_MRD);
      S_WR_MEM:   state_next = S_IF1;
      S_STR_B:    state_next = S_STR_C;
      S_STR_C:    state_next = S_MWR;
      S_MWR:      state_next = mem_rdy ? S_IF1 : (wait_last ? S_ERR : S_MWR);
      S_BR_TAKEN, S_BR_SKIP: state_next = S_IF1;
      // BL finishes with the relative PC load; BLX continues into the BX path.
      S_LINK:     state_next = (op == OP_BL) ? S_BR_TAKEN : S_BX_B;
      S_BX_B:     state_next = S_BX_C;
      S_BX_C:     state_next = S_BX_PC;
      S_BX_PC:    state_next = S_IF1;
      S_HALT:     state_next = resume ? S_IF1 : S_HALT;
      S_ERR:      state_next = S_ERR;
      default:    state_next = S_ERR;
    endcase
  end

  always_comb begin
    vsel      = 4'b0000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    nsel      = 3'b000;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    pc_sel    = PCSEL_INC;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    err       = 1'b0;
    case (state)
      S_RST:      begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:      begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      S_IF2:      begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
      S_UPDATE:   begin load_pc = 1'b1; pc_sel = PCSEL_INC; end
      S_MOVI:     begin write = 1'b1; vsel = VSEL_SXIMM8; nsel = NSEL_RN; end
      S_GET_A:    begin loada = 1'b1; nsel = NSEL_RN; end
      S_GET_B:    begin loadb = 1'b1; nsel = NSEL_RM; end
      S_SHIFT:    begin asel = 1'b1; loadc = 1'b1; end
      S_ALU:      loadc = 1'b1;
      S_WR_C:     begin write = 1'b1; vsel = VSEL_C; nsel = NSEL_RD; end
      S_LOADS:    loads = 1'b1;
      S_ADDR:     begin bsel = 1'b1; loadc = 1'b1; end
      S_LD_ADDR:  load_addr = 1'b1;
      S_MRD:      mem_cmd = MEM_READ;
      S_WR_MEM:   begin write = 1'b1; vsel = VSEL_MDATA; nsel = NSEL_RD; end
      S_STR_B:    begin loadb = 1'b1; nsel = NSEL_RD; end
      S_STR_C:    begin asel = 1'b1; loadc = 1'b1; end
      S_MWR:      mem_cmd = MEM_WRITE;
      S_BR_TAKEN: begin load_pc = 1'b1; pc_sel = PCSEL_REL; end
      S_LINK:     begin write = 1'b1; vsel = VSEL_PC; nsel = NSEL_RN; end
      S_BX_B:     begin loadb = 1'b1; nsel = NSEL_RD; end
      S_BX_C:     begin asel = 1'b1; loadc = 1'b1; end
      S_BX_PC:    begin load_pc = 1'b1; pc_sel = PCSEL_REG; end
      S_HALT:     halted = 1'b1;
      S_ERR:      err = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: instruction-level reference model feeding per-cycle
// expected control words into queues, compared by an independent monitor.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  localparam int MAXW = 4;

  typedef struct packed {
    logic [3:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0] nsel;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0] pc_sel, mem_cmd;
    logic       halted, err;
  } ctl_t;
  localparam int W = $bits(ctl_t);

  typedef struct packed {
    logic [W-1:0] w;
    logic         rdy, rst, res, br;
  } step_t;

  // clock / reset and shared inputs
  logic       clk;
  logic       reset, mem_rdy, resume, n_flag, z_flag, v_flag;
  logic [2:0] opcode, cond;
  logic [1:0] op;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: branches enabled; DUT B: branches disabled
  logic [3:0] a_vsel, b_vsel;
  logic       a_write, a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel;
  logic       b_write, b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel;
  logic [2:0] a_nsel, b_nsel;
  logic       a_load_ir, a_load_pc, a_reset_pc, a_addr_sel, a_load_addr;
  logic       b_load_ir, b_load_pc, b_reset_pc, b_addr_sel, b_load_addr;
  logic [1:0] a_pc_sel, a_mem_cmd, b_pc_sel, b_mem_cmd;
  logic       a_halted, a_err, b_halted, b_err;
  state_t     a_state, b_state;

  cpu_ctrl_fsm #(.MEM_WAIT_MAX(MAXW), .BRANCH_EN(1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(n_flag), .Z(z_flag), .V(v_flag), .mem_rdy(mem_rdy), .resume(resume),
    .vsel(a_vsel), .write(a_write), .loada(a_loada), .loadb(a_loadb),
    .loadc(a_loadc), .loads(a_loads), .asel(a_asel), .bsel(a_bsel),
    .nsel(a_nsel), .load_ir(a_load_ir), .load_pc(a_load_pc),
    .reset_pc(a_reset_pc), .addr_sel(a_addr_sel), .load_addr(a_load_addr),
    .pc_sel(a_pc_sel), .mem_cmd(a_mem_cmd), .halted(a_halted), .err(a_err),
    .dbg_state(a_state)
  );

  cpu_ctrl_fsm #(.MEM_WAIT_MAX(MAXW), .BRANCH_EN(0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(n_flag), .Z(z_flag), .V(v_flag), .mem_rdy(mem_rdy), .resume(resume),
    .vsel(b_vsel), .write(b_write), .loada(b_loada), .loadb(b_loadb),
    .loadc(b_loadc), .loads(b_loads), .asel(b_asel), .bsel(b_bsel),
    .nsel(b_nsel), .load_ir(b_load_ir), .load_pc(b_load_pc),
    .reset_pc(b_reset_pc), .addr_sel(b_addr_sel), .load_addr(b_load_addr),
    .pc_sel(b_pc_sel), .mem_cmd(b_mem_cmd), .halted(b_halted), .err(b_err),
    .dbg_state(b_state)
  );

  logic [W-1:0] act_a, act_b;
  assign act_a = {a_vsel, a_write, a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel,
                  a_nsel, a_load_ir, a_load_pc, a_reset_pc, a_addr_sel, a_load_addr,
                  a_pc_sel, a_mem_cmd, a_halted, a_err};
  assign act_b = {b_vsel, b_write, b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel,
                  b_nsel, b_load_ir, b_load_pc, b_reset_pc, b_addr_sel, b_load_addr,
                  b_pc_sel, b_mem_cmd, b_halted, b_err};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] e_a, e_b;
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  string        phase = "reset";

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e_a = exp_q.pop_front();
      checks++;
      if (act_a === e_a) passes++;
      else $display("FAIL ctl_a [%s] cycle %0d state %s: got %h want %h",
                    phase, cyc, a_state.name(), act_a, e_a);
    end
    if (exp2_q.size() > 0) begin
      e_b = exp2_q.pop_front();
      checks++;
      if (act_b === e_b) passes++;
      else $display("FAIL ctl_b [%s] cycle %0d state %s: got %h want %h",
                    phase, cyc, b_state.name(), act_b, e_b);
    end
  end

  // expected control words, straight from the per-state output table
  function automatic logic [W-1:0] w_fetch(input bit ir);
    ctl_t c = '0;
    c.addr_sel = 1'b1; c.mem_cmd = 2'b01; c.load_ir = ir;
    return c;
  endfunction

  function automatic logic [W-1:0] w_pc(input logic [1:0] sel, input bit rst);
    ctl_t c = '0;
    c.load_pc = 1'b1; c.pc_sel = sel; c.reset_pc = rst;
    return c;
  endfunction

  function automatic logic [W-1:0] w_reg(input bit la, input bit lb, input logic [2:0] ns);
    ctl_t c = '0;
    c.loada = la; c.loadb = lb; c.nsel = ns;
    return c;
  endfunction

  function automatic logic [W-1:0] w_c(input bit as, input bit bs);
    ctl_t c = '0;
    c.loadc = 1'b1; c.asel = as; c.bsel = bs;
    return c;
  endfunction

  function automatic logic [W-1:0] w_wr(input logic [3:0] vs, input logic [2:0] ns);
    ctl_t c = '0;
    c.write = 1'b1; c.vsel = vs; c.nsel = ns;
    return c;
  endfunction

  function automatic logic [W-1:0] w_mem(input logic [1:0] cmd);
    ctl_t c = '0;
    c.mem_cmd = cmd;
    return c;
  endfunction

  // 0 idle, 1 loads, 2 load_addr, 3 halted, 4 err
  function automatic logic [W-1:0] w_flag(input int k);
    ctl_t c = '0;
    c.loads = (k == 1); c.load_addr = (k == 2); c.halted = (k == 3); c.err = (k == 4);
    return c;
  endfunction

  // reference model: builds the per-cycle step list for one instruction
  step_t sq[$];
  bit    pending_rst = 1'b1;
  bit    nb_err = 1'b0;

  task automatic add(input logic [W-1:0] w, input int rdy = -1, input bit rst = 0,
                     input int res = -1, input bit br = 0);
    step_t s;
    s.w   = w;
    s.rdy = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
    s.res = (res < 0) ? 1'($urandom_range(0, 1)) : 1'(res);
    s.rst = rst;
    s.br  = br;
    sq.push_back(s);
  endtask

  task automatic err_tail();
    int k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) add(w_flag(4), -1, (i == k - 1));
    pending_rst = 1'b1;
  endtask

  task automatic mem_wait(input logic [W-1:0] w, input int mw, output bit timed_out);
    for (int i = 0; i < mw && i < MAXW; i++) add(w, 0);
    timed_out = (mw >= MAXW);
    if (timed_out) err_tail();
    else add(w, 1);
  endtask

  function automatic bit cond_taken(input logic [2:0] cd, input bit n, input bit z,
                                    input bit v, output bit bad);
    bit lt = (n != v);
    bad = 1'b0;
    case (cd)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return lt;
      3'd4: return lt || z;
      default: begin bad = 1'b1; return 1'b0; end
    endcase
  endfunction

  task automatic build(input logic [2:0] oc, input logic [1:0] o, input logic [2:0] cd,
                       input bit n, input bit z, input bit v,
                       input int ifw, input int mw, input int hc);
    bit to, bad, tk;
    if (pending_rst) begin
      add(w_pc(2'b00, 1));
      pending_rst = 1'b0;
    end
    for (int i = 0; i < ifw && i < MAXW; i++) add(w_fetch(0), 0);
    if (ifw >= MAXW) begin
      err_tail();
      return;
    end
    add(w_fetch(0), 1);
    add(w_fetch(1));
    add(w_pc(2'b00, 0));
    add(w_flag(0), -1, 0, -1, (oc == 3'b001 || oc == 3'b010));
    case ({oc, o})
      5'b110_10: add(w_wr(4'b0100, 3'b100));
      5'b110_00: begin
        add(w_reg(0, 1, 3'b001)); add(w_c(1, 0)); add(w_wr(4'b0001, 3'b010));
      end
      5'b101_00, 5'b101_10: begin
        add(w_reg(1, 0, 3'b100)); add(w_reg(0, 1, 3'b001));
        add(w_c(0, 0)); add(w_wr(4'b0001, 3'b010));
      end
      5'b101_01: begin
        add(w_reg(1, 0, 3'b100)); add(w_reg(0, 1, 3'b001)); add(w_flag(1));
      end
      5'b101_11: begin
        add(w_reg(0, 1, 3'b001)); add(w_c(0, 0)); add(w_wr(4'b0001, 3'b010));
      end
      5'b011_00: begin
        add(w_reg(1, 0, 3'b100)); add(w_c(0, 1)); add(w_flag(2));
        mem_wait(w_mem(2'b01), mw, to);
        if (!to) add(w_wr(4'b1000, 3'b010));
      end
      5'b100_00: begin
        add(w_reg(1, 0, 3'b100)); add(w_c(0, 1)); add(w_flag(2));
        add(w_reg(0, 1, 3'b010)); add(w_c(1, 0));
        mem_wait(w_mem(2'b10), mw, to);
      end
      5'b111_00: begin
        for (int i = 0; i < hc; i++) add(w_flag(3), -1, 0, (i == hc - 1));
      end
      5'b001_00: begin
        tk = cond_taken(cd, n, z, v, bad);
        if (bad) err_tail();
        else if (tk) add(w_pc(2'b01, 0));
        else add(w_flag(0));
      end
      5'b010_11: begin
        add(w_wr(4'b0010, 3'b100)); add(w_pc(2'b01, 0));
      end
      5'b010_00: begin
        add(w_reg(0, 1, 3'b010)); add(w_c(1, 0)); add(w_pc(2'b10, 0));
      end
      5'b010_10: begin
        add(w_wr(4'b0010, 3'b100));
        add(w_reg(0, 1, 3'b010)); add(w_c(1, 0)); add(w_pc(2'b10, 0));
      end
      default: err_tail();
    endcase
  endtask

  // driver: one step per cycle, inputs applied just after the rising edge
  task automatic play();
    step_t s;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      mem_rdy = s.rdy;
      reset   = s.rst;
      resume  = s.res;
      exp_q.push_back(s.w);
      exp2_q.push_back(nb_err ? w_flag(4) : s.w);
      if (s.rst) nb_err = 1'b0;
      else if (s.br) nb_err = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic instr(input string name, input logic [2:0] oc, input logic [1:0] o,
                       input logic [2:0] cd, input bit n, input bit z, input bit v,
                       input int ifw, input int mw, input int hc);
    phase  = name;
    opcode = oc; op = o; cond = cd;
    n_flag = n; z_flag = z; v_flag = v;
    build(oc, o, cd, n, z, v, ifw, mw, hc);
    play();
  endtask

  task automatic reset_in_if1(input int k);
    phase = "reset_in_if1";
    for (int i = 0; i < k; i++) add(w_fetch(0), 0, (i == k - 1));
    pending_rst = 1'b1;
    play();
  endtask

  logic [4:0] legal[13];
  logic [2:0] r_oc, r_cd;
  logic [1:0] r_o;
  int         sel;

  initial begin
    legal = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_10, 5'b101_01, 5'b101_11,
              5'b011_00, 5'b100_00, 5'b111_00, 5'b001_00, 5'b010_11, 5'b010_00,
              5'b010_10};
    reset = 1'b1; mem_rdy = 1'b0; resume = 1'b0;
    opcode = '0; op = '0; cond = '0;
    n_flag = 1'b0; z_flag = 1'b0; v_flag = 1'b0;
    @(posedge clk);
    #1;

    // directed cases
    instr("movi",      3'b110, 2'b10, 3'd0, 0, 0, 0, 0, 0, 0);
    instr("ldr_wait3", 3'b011, 2'b00, 3'd0, 0, 0, 0, 0, 3, 0);
    instr("str_tmo",   3'b100, 2'b00, 3'd0, 0, 0, 0, 0, MAXW, 0);
    instr("beq_t",     3'b001, 2'b00, 3'd1, 0, 1, 0, 0, 0, 0);
    instr("beq_nt",    3'b001, 2'b00, 3'd1, 0, 0, 0, 1, 0, 0);
    instr("blt_t",     3'b001, 2'b00, 3'd3, 1, 0, 0, 0, 0, 0);
    instr("b_badcond", 3'b001, 2'b00, 3'd6, 0, 0, 0, 0, 0, 0);
    instr("blx",       3'b010, 2'b10, 3'd0, 0, 0, 0, 2, 0, 0);
    instr("halt10",    3'b111, 2'b00, 3'd0, 0, 0, 0, 0, 0, 10);
    reset_in_if1(2);
    instr("if1_tmo",   3'b110, 2'b10, 3'd0, 0, 0, 0, MAXW, 0, 0);

    // randomized instruction stream
    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 15);
      if (sel < 13) {r_oc, r_o} = legal[sel];
      else {r_oc, r_o} = 5'($urandom_range(0, 31));
      r_cd = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      instr("random", r_oc, r_o, r_cd,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3),
            $urandom_range(1, 5));
      if (!pending_rst && $urandom_range(0, 9) == 0) reset_in_if1($urandom_range(1, 3));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multicycle control unit for the simple RISC CPU. It is the parametrised successor of the lab-7 controller. It sequences fetch, decode and execute for the ALU, memory, branch and halt instructions, and drives every datapath, PC and memory-interface control line. It adds four things the lab-7 controller lacks: a variable-latency memory handshake with timeout, conditional and link branches, a resumable HALT, and a sticky error state for illegal opcodes.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum cycles a memory state waits for `mem_rdy` before going to ERR; range 1..255.
- `BRANCH_EN`, default 1: 1 decodes the branch opcodes 001 and 010; 0 treats them as illegal.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 3, `op` in 2, `cond` in 3: instruction register fields, with `cond` = IR[10:8].
- `N`, `Z`, `V` in 1 each: status flags.
- `mem_rdy` in 1: memory has completed the current read or write.
- `resume` in 1: leave HALT.
- `vsel` out 4: one-hot write-back source; 1000 mdata, 0100 sximm8, 0010 PC, 0001 C.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` out 1 each: datapath controls.
- `nsel` out 3: one-hot register select; 100 Rn, 010 Rd, 001 Rm.
- `load_ir`, `load_pc`, `reset_pc`, `addr_sel`, `load_addr` out 1 each: fetch/PC controls.
- `pc_sel` out 2: next PC; 00 PC+1, 01 PC+sximm8, 10 datapath_out.
- `mem_cmd` out 2: 00 none, 01 read, 10 write.
- `halted`, `err` out 1 each: status.

## Operation
- Outputs are Moore outputs, decoded combinationally from the state register only. Every output not listed for a state is 0.
- Reset: the state becomes RST. In RST, `reset_pc`=1 and `load_pc`=1; all other outputs are 0.
- Fetch sequence RST→IF1→IF2→UPDATE→DECODE.
  - IF1: `addr_sel`=1, `mem_cmd`=01. Stays in IF1 until `mem_rdy`.
  - IF2: `addr_sel`=1, `mem_cmd`=01, `load_ir`=1.
  - UPDATE: `load_pc`=1, `pc_sel`=00.
- DECODE uses {opcode,op}; anything else goes to ERR.
  - 110_10 MOVI: Rd←sximm8 (`vsel` 0100, `nsel` 100, `write`).
  - 110_00 MOV: B←Rm; C←shift(B) with `asel`=1; Rd←C.
  - 101_00 ADD and 101_10 AND: A←Rn; B←Rm; C←ALU; Rd←C.
  - 101_01 CMP: A←Rn; B←Rm; `loads`.
  - 101_11 MVN: B←Rm; C←ALU; Rd←C.
  - 011_00 LDR: A←Rn; C←A+sximm5 (`bsel`); `load_addr`; MRD (`mem_cmd` 01) waits for `mem_rdy`; Rd←mdata.
  - 100_00 STR: A←Rn; C←A+sximm5; `load_addr`; B←Rd; C←B (`asel`); MWR (`mem_cmd` 10) waits for `mem_rdy`.
  - 111_00 HALT.
  - 001_00 B<cond>: one state with `load_pc`=1 and `pc_sel`=01, only when taken.
    - cond 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V)|Z.
    - Other cond values are illegal: no PC load, go to ERR.
  - 010_11 BL: R7←PC (`vsel` 0010, `nsel` 100), then PC←PC+sximm8.
  - 010_00 BX: B←Rd; C←B (`asel`); PC←C (`pc_sel` 10).
  - 010_10 BLX: R7←PC, then the BX sequence.
- Every execute sequence returns to IF1.
- Wait counter: $clog2(MEM_WAIT_MAX+1) bits.
  - Cleared on entry to IF1, MRD or MWR.
  - Increments each cycle the FSM stays there with `mem_rdy`=0.
  - Reaching MEM_WAIT_MAX with `mem_rdy` still 0 → ERR.
- HALT: `halted`=1. `resume`=1 → IF1, with PC already pointing past the HALT.
- ERR: `err`=1 and no PC load. Only `reset` exits ERR.
- `reset` has priority over every state, including mid-wait, HALT and ERR.

## Timing
- Reset takes effect at the first rising edge with `reset`=1. The outputs of RST appear after that edge.
- Fetch with zero wait takes 4 cycles: IF1 (where `mem_rdy` is sampled at the end of the cycle), IF2, UPDATE, DECODE. Each wait cycle adds 1.
- Execute length in cycles:
  - MOVI 1.
  - MOV, MVN, CMP 3.
  - ADD, AND 4.
  - LDR 5 + waits.
  - STR 6 + waits.
  - B 1, BL 2, BX 3, BLX 4.
- `mem_rdy` sampled in the same cycle as entering a wait state ends that state after 1 cycle.
- Timeout: ERR is entered after exactly MEM_WAIT_MAX cycles in one wait state.

## Structure
- A shared package `cpu_pkg` holds:
  - the state enum,
  - the opcode/op/cond localparams,
  - the `vsel`, `nsel`, `pc_sel` and `mem_cmd` encodings.
- One sub-module, `br_cond_eval`, is combinational: (cond, N, Z, V) → taken, illegal.

## Test plan
- Reset, then MOVI R0,#5 with `mem_rdy` tied to 1 → state sequence RST,IF1,IF2,UPDATE,DECODE,MOVI,IF1. `write`=1 and `vsel`=0100 in the MOVI cycle.
- LDR with `mem_rdy` held low 3 cycles in MRD → `mem_cmd`=01 for 4 cycles, then `write`=1 with `vsel`=1000.
- STR with MEM_WAIT_MAX=4 and `mem_rdy` never asserted → `err`=1 after 4 MWR cycles. `err` stays 1 until `reset`, then the FSM goes to RST.
- BEQ with Z=1 → `load_pc`=1 and `pc_sel`=01. BEQ with Z=0 → no `load_pc`, next state IF1. BLT with N=1, V=0 → taken.
- BLX → R7 write (`vsel` 0010, `nsel` 100), then `pc_sel`=10 with `load_pc` 3 cycles later. The same instruction with BRANCH_EN=0 → ERR.
- HALT held 10 cycles → `halted`=1 throughout. Then `resume` → IF1. `reset` asserted during IF1 wait → RST on the next edge.
